// File: rtl/packet_route_buffer.sv
// Input buffer that steers its FIFO head to the local or forward port by address.
// Optional macro PKT_ROUTE_STATS_EN adds saturating per-port pop counters.
module packet_route_buffer #(
  parameter int unsigned PKT_W      = 33,
  parameter int unsigned ADDR_START = 32,
  parameter int unsigned ADDR_END   = 29,
  parameter int unsigned DEPTH      = 4,
  parameter logic [ADDR_START-ADDR_END:0] LOCAL_ADDR = 4'h3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PKT_W-1:0]         in_packet,
  output logic                     local_valid,
  input  logic                     local_ready,
  output logic [PKT_W-1:0]         local_packet,
  output logic                     fwd_valid,
  input  logic                     fwd_ready,
  output logic [PKT_W-1:0]         fwd_packet,
`ifdef PKT_ROUTE_STATS_EN
  output logic [15:0]              local_pkt_cnt,
  output logic [15:0]              fwd_pkt_cnt,
`endif
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic             push, pop, not_empty, head_is_local;
  logic [PKT_W-1:0] head;

  assign head          = mem_q[rd_ptr_q];
  assign not_empty     = (occ_q != '0);
  assign head_is_local = (head[ADDR_START:ADDR_END] == LOCAL_ADDR);

  // in_ready comes only from registered occupancy, so a full buffer never pushes
  // even when the head is leaving in the same cycle.
  assign in_ready     = (occ_q != OCC_W'(DEPTH));
  assign local_valid  = not_empty && head_is_local;
  assign fwd_valid    = not_empty && !head_is_local;
  assign local_packet = head;
  assign fwd_packet   = head;
  assign occupancy    = occ_q;

  assign push = in_valid && in_ready;
  assign pop  = (local_valid && local_ready) || (fwd_valid && fwd_ready);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (pop && !push) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (push) mem_q[wr_ptr_q] <= in_packet;
    end
  end

`ifdef PKT_ROUTE_STATS_EN
  logic [15:0] local_cnt_q, local_cnt_d;
  logic [15:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    local_cnt_d = local_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (local_valid && local_ready && (local_cnt_q != '1)) local_cnt_d = local_cnt_q + 16'd1;
    if (fwd_valid && fwd_ready && (fwd_cnt_q != '1))       fwd_cnt_d   = fwd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      local_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      local_cnt_q <= local_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign local_pkt_cnt = local_cnt_q;
  assign fwd_pkt_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_packet_route_buffer.sv
// Scoreboard bench for packet_route_buffer: queue reference model checked every cycle.
module tb_packet_route_buffer;

  localparam int unsigned PKT_W = 33;
  localparam int unsigned DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [PKT_W-1:0]  in_packet;
  logic              local_valid, local_ready, fwd_valid, fwd_ready;
  logic [PKT_W-1:0]  local_packet, fwd_packet;
  logic [2:0]        occupancy;
`ifdef PKT_ROUTE_STATS_EN
  logic [15:0]       local_pkt_cnt, fwd_pkt_cnt;
`endif

  always #5 clk = ~clk;

  packet_route_buffer #(
    .PKT_W(PKT_W), .ADDR_START(32), .ADDR_END(29), .DEPTH(DEPTH), .LOCAL_ADDR(4'h3)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
    .local_valid(local_valid), .local_ready(local_ready), .local_packet(local_packet),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_packet(fwd_packet),
`ifdef PKT_ROUTE_STATS_EN
    .local_pkt_cnt(local_pkt_cnt), .fwd_pkt_cnt(fwd_pkt_cnt),
`endif
    .occupancy(occupancy)
  );

  int          errors = 0;
  int          checks = 0;
  logic [32:0] sb_q[$];
  int unsigned m_lcnt, m_fcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the queue model, then advances the model
  // by the transfers that the coming rising edge will perform.
  always @(negedge clk) begin : monitor
    logic        has, is_loc, do_pop, do_push;
    logic [32:0] h;
    if (reset) begin
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_local_valid", 64'(local_valid), 64'd0);
      chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_local_packet", 64'(local_packet), 64'd0);
      chk("rst_fwd_packet", 64'(fwd_packet), 64'd0);
      sb_q.delete();
      m_lcnt = 0;
      m_fcnt = 0;
`ifdef PKT_ROUTE_STATS_EN
      chk("rst_local_cnt", 64'(local_pkt_cnt), 64'd0);
      chk("rst_fwd_cnt", 64'(fwd_pkt_cnt), 64'd0);
`endif
    end else begin
      has    = (sb_q.size() != 0);
      h      = has ? sb_q[0] : '0;
      is_loc = (h[32:29] == 4'h3);
      chk("in_ready", 64'(in_ready), 64'(sb_q.size() != DEPTH));
      chk("occupancy", 64'(occupancy), 64'(sb_q.size()));
      chk("local_valid", 64'(local_valid), 64'(has && is_loc));
      chk("fwd_valid", 64'(fwd_valid), 64'(has && !is_loc));
      if (has) begin
        chk("local_packet", 64'(local_packet), 64'(h));
        chk("fwd_packet", 64'(fwd_packet), 64'(h));
      end
`ifdef PKT_ROUTE_STATS_EN
      chk("local_cnt", 64'(local_pkt_cnt), 64'(m_lcnt));
      chk("fwd_cnt", 64'(fwd_pkt_cnt), 64'(m_fcnt));
`endif
      do_pop  = has && (is_loc ? local_ready : fwd_ready);
      do_push = in_valid && (sb_q.size() != DEPTH);
      if (do_pop) begin
        void'(sb_q.pop_front());
        if (is_loc) begin
          if (m_lcnt < 65535) m_lcnt++;
        end else begin
          if (m_fcnt < 65535) m_fcnt++;
        end
      end
      if (do_push) sb_q.push_back(in_packet);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [32:0] p, input logic lr, input logic fr);
    in_valid    = v;
    in_packet   = p;
    local_ready = lr;
    fwd_ready   = fr;
  endtask

  function automatic logic [32:0] rand_pkt(input logic local_dst);
    logic [32:0] p;
    p = {1'b0, $urandom()};
    p[32] = $urandom_range(0, 1) != 0;
    if (local_dst) p[32:29] = 4'h3;
    else if (p[32:29] == 4'h3) p[32:29] = 4'h9;
    return p;
  endfunction

  initial begin
    reset = 1'b1;
    drive(1'b1, rand_pkt(1'b1), 1'b1, 1'b1);
    #1;
    step(3);
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step(2);

    // single local packet held, then accepted
    drive(1'b1, 33'h0_6400_0005, 1'b0, 1'b0);
    step(1);
    drive(1'b0, '0, 1'b0, 1'b0);
    step(2);
    drive(1'b0, '0, 1'b1, 1'b0);
    step(1);
    drive(1'b0, '0, 1'b0, 1'b0);
    step(1);

    // forward head blocks a local packet behind it
    drive(1'b1, 33'h0_A200_0123, 1'b1, 1'b0);
    step(1);
    drive(1'b1, 33'h0_6400_0005, 1'b1, 1'b0);
    step(1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step(3);
    drive(1'b0, '0, 1'b1, 1'b1);
    step(3);

    // fill to full, fifth offer refused, one pop reopens
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, rand_pkt(i[0]), 1'b0, 1'b0);
      step(1);
    end
    drive(1'b1, rand_pkt(1'b0), 1'b1, 1'b1);
    step(1);
    drive(1'b1, in_packet, 1'b0, 1'b0);
    step(1);
    drive(1'b0, '0, 1'b1, 1'b1);
    step(DEPTH + 2);

    // reset while holding packets
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_pkt(i[0]), 1'b0, 1'b0);
      step(1);
    end
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step(2);

    // streaming, alternating destinations
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, rand_pkt(i[0]), 1'b1, 1'b1);
      step(1);
    end
    drive(1'b0, '0, 1'b1, 1'b1);
    step(3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, rand_pkt($urandom_range(0, 1) != 0),
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      step(1);
    end
    drive(1'b0, '0, 1'b1, 1'b1);
    step(DEPTH + 2);

`ifdef PKT_ROUTE_STATS_EN
    // drive the local counter past its ceiling
    for (int i = 0; i < 65545; i++) begin
      drive(1'b1, rand_pkt(1'b1), 1'b1, 1'b0);
      step(1);
    end
    drive(1'b0, '0, 1'b1, 1'b1);
    step(DEPTH + 2);
    chk("local_cnt_sat", 64'(local_pkt_cnt), 64'hFFFF);
`endif

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
